fir_input_arbiter: RTL and testbench

Round-robin scheduler that shares one FIR filter input between N_CH deserializer channels. It captures one parallel word from the granted channel, acknowledges that channel, and presents the word with its channel tag to the FIR under a valid/ready handshake. It sits between the per-channel deserializers and the single FIR instance, and includes a stall watchdog on the FIR side.

---
 rtl/fir_pkg.sv | 20 ++
 rtl/fir_input_arbiter_if.sv | 33 +++
 rtl/rr_priority_picker.sv | 29 ++
 rtl/fir_input_arbiter.sv | 119 +++++++++++
 tb/tb_fir_input_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the deserializer -> arbiter -> FIR path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fir_pkg;

  // Default word width shared by the deserializers, arbiter and FIR.
  localparam int FIR_LENGTH = 16;

  // One-hot arbiter states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b01,
    ST_ISSUE = 2'b10
  } arb_state_t;

  // Channel-tag width: max(1, clog2(n)).
  function automatic int ch_bits(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_input_arbiter_if.sv
// Bundle between the deserializer channels, the arbiter and the FIR input.
// Latency: n/a (wiring only).
// Backpressure: FIR side is valid/ready; channel side is valid plus a one-cycle ack pulse.
interface fir_input_arbiter_if
  import fir_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int LENGTH = FIR_LENGTH
);
  localparam int CH_BITS = ch_bits(N_CH);

  logic [N_CH-1:0]        iv_ch_en;
  logic [N_CH-1:0]        iv_din_valid;
  logic [N_CH*LENGTH-1:0] ivv_din;
  logic [N_CH-1:0]        ov_ack;
  logic                   i_fir_ready;
  logic [LENGTH-1:0]      ov_dout;
  logic [CH_BITS-1:0]     ov_dout_ch;
  logic                   o_dout_valid;

  // Arbiter side.
  modport master (
    input  iv_ch_en, iv_din_valid, ivv_din, i_fir_ready,
    output ov_ack, ov_dout, ov_dout_ch, o_dout_valid
  );

  // Environment side (deserializers + FIR).
  modport slave (
    output iv_ch_en, iv_din_valid, ivv_din, i_fir_ready,
    input  ov_ack, ov_dout, ov_dout_ch, o_dout_valid
  );

endinterface

// File: rtl/rr_priority_picker.sv
// Round-robin pick: first set req bit above last_grant, wrapping to channel 0.
// Latency: combinational.
// Backpressure: none; any_req reports whether a grant is meaningful.
module rr_priority_picker
  import fir_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CH_BITS = ch_bits(N_CH)
) (
  input  logic [N_CH-1:0]    req,
  input  logic [CH_BITS-1:0] last_grant,
  output logic [CH_BITS-1:0] grant,
  output logic               any_req
);

  // Two descending passes: wrapped channels (<= last_grant) first, then channels above
  // last_grant overwrite them, so the nearest requester past last_grant wins.
  always_comb begin
    grant   = '0;
    any_req = |req;
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (req[c] && (c <= int'(last_grant))) grant = CH_BITS'(c);
    end
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (req[c] && (c > int'(last_grant))) grant = CH_BITS'(c);
    end
  end

endmodule

// File: rtl/fir_input_arbiter.sv
// Round-robin share of one FIR input among N_CH deserializer channels, with stall watchdog.
// Latency: 1 cycle from eligible request in IDLE to o_dout_valid; at most one word per 2 cycles.
// Backpressure: word held stable while i_fir_ready is low; sticky o_timeout after TIMEOUT stalled cycles.
module fir_input_arbiter
  import fir_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int LENGTH  = FIR_LENGTH,
  parameter int TIMEOUT = 255
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  fir_input_arbiter_if.master bus,
  output logic                o_timeout,
  output logic                o_busy
);

  localparam int CH_BITS = ch_bits(N_CH);
  localparam int WD_BITS = $clog2(TIMEOUT + 1);
  localparam logic [WD_BITS-1:0] WD_MAX = WD_BITS'(TIMEOUT);

  arb_state_t          state_q, state_d;
  logic [CH_BITS-1:0]  last_grant_q;
  logic [N_CH-1:0]     ack_q;
  logic [LENGTH-1:0]   dout_q;
  logic [CH_BITS-1:0]  dout_ch_q;
  logic                dout_vld_q;
  logic [WD_BITS-1:0]  wdog_q;
  logic [WD_BITS-1:0]  wdog_inc;
  logic                timeout_q;

  logic [N_CH-1:0]     req;
  logic [CH_BITS-1:0]  grant;
  logic                any_req;
  logic [LENGTH-1:0]   grant_word;
  logic                capture;
  logic                handshake;

  // The channel acked last cycle is still dropping its valid, so the ack mask doubles as the block mask.
  assign req = bus.iv_din_valid & bus.iv_ch_en & ~ack_q;

  rr_priority_picker #(
    .N_CH    (N_CH),
    .CH_BITS (CH_BITS)
  ) u_picker (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (grant),
    .any_req    (any_req)
  );

  // Select the granted channel's word from the packed input bus.
  always_comb begin
    grant_word = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (grant == CH_BITS'(c)) grant_word = bus.ivv_din[c*LENGTH +: LENGTH];
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst)     state_q <= ST_IDLE;
    else if (i_en) state_q <= state_d;
  end

  // Next-state: capture from IDLE when anything is eligible, return on FIR handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (any_req) state_d = ST_ISSUE;
      ST_ISSUE: if (dout_vld_q && bus.i_fir_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State-decoded controls; i_fir_ready is only honoured in ISSUE.
  always_comb begin
    capture   = (state_q == ST_IDLE) && any_req;
    handshake = (state_q == ST_ISSUE) && dout_vld_q && bus.i_fir_ready;
    o_busy    = (state_q != ST_IDLE);
    wdog_inc  = (wdog_q == WD_MAX) ? wdog_q : wdog_q + 1'b1;
  end

  // Capture/ack datapath, watchdog and sticky timeout flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_grant_q <= CH_BITS'(N_CH - 1);
      ack_q        <= '0;
      dout_q       <= '0;
      dout_ch_q    <= '0;
      dout_vld_q   <= 1'b0;
      wdog_q       <= '0;
      timeout_q    <= 1'b0;
    end else if (i_en) begin
      ack_q <= '0;
      if (capture) begin
        dout_q       <= grant_word;
        dout_ch_q    <= grant;
        dout_vld_q   <= 1'b1;
        ack_q        <= {{(N_CH-1){1'b0}}, 1'b1} << grant;
        last_grant_q <= grant;
        wdog_q       <= '0;
      end else if (handshake) begin
        dout_vld_q <= 1'b0;
      end else if (state_q == ST_ISSUE) begin
        wdog_q <= wdog_inc;
        if (wdog_inc == WD_MAX) timeout_q <= 1'b1;
      end
    end
  end

  assign bus.ov_ack       = ack_q;
  assign bus.ov_dout      = dout_q;
  assign bus.ov_dout_ch   = dout_ch_q;
  assign bus.o_dout_valid = dout_vld_q;
  assign o_timeout        = timeout_q;

endmodule

// File: tb/tb_fir_input_arbiter.sv
// Directed bench for fir_input_arbiter (N_CH=4, LENGTH=16, TIMEOUT=8).
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Expected values are hand-computed constants per vector.
module tb_fir_input_arbiter;

  logic clk;
  logic rst;
  logic en;
  logic timeout;
  logic busy;
  int   n_checks;
  int   n_errors;
  int   ack_pulses;

  fir_input_arbiter_if #(.N_CH(4), .LENGTH(16)) bus ();

  fir_input_arbiter #(
    .N_CH    (4),
    .LENGTH  (16),
    .TIMEOUT (8)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_en      (en),
    .bus       (bus),
    .o_timeout (timeout),
    .o_busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_word(input int c, input logic [15:0] w);
    bus.ivv_din[c*16 +: 16] = w;
  endtask

  task automatic chk_grant(input string tag, input int c, input logic [15:0] w);
    chk({tag, "_vld"}, 32'(bus.o_dout_valid), 32'd1);
    chk({tag, "_ch"},  32'(bus.ov_dout_ch), 32'(c));
    chk({tag, "_dat"}, 32'(bus.ov_dout), 32'(w));
    chk({tag, "_ack"}, 32'(bus.ov_ack), 32'(4'b0001 << c));
  endtask

  initial begin
    int seq5 [6];
    n_checks = 0;
    n_errors = 0;
    seq5 = '{0, 1, 3, 0, 1, 3};
    rst = 1'b1;
    en  = 1'b1;
    bus.iv_ch_en     = 4'hF;
    bus.iv_din_valid = 4'h0;
    bus.ivv_din      = '0;
    bus.i_fir_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_ack",  32'(bus.ov_ack), 32'd0);
    chk("rst_dout", 32'(bus.ov_dout), 32'd0);
    chk("rst_ch",   32'(bus.ov_dout_ch), 32'd0);
    chk("rst_vld",  32'(bus.o_dout_valid), 32'd0);
    chk("rst_to",   32'(timeout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // 1: single request on channel 2
    set_word(2, 16'hA5A5);
    bus.iv_din_valid = 4'b0100;
    bus.i_fir_ready  = 1'b1;
    tick();
    chk_grant("t1", 2, 16'hA5A5);
    chk("t1_busy", 32'(busy), 32'd1);
    bus.iv_din_valid = 4'b0000;
    tick();
    chk("t1_vld_drop", 32'(bus.o_dout_valid), 32'd0);
    chk("t1_idle",     32'(busy), 32'd0);
    chk("t1_ack_drop", 32'(bus.ov_ack), 32'd0);

    // 2: all channels continuously valid, rotation 0,1,2,3,0
    do_reset();
    for (int c = 0; c < 4; c++) set_word(c, 16'h1000 + 16'(c));
    bus.iv_din_valid = 4'hF;
    bus.i_fir_ready  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_grant($sformatf("t2_g%0d", k), k % 4, 16'h1000 + 16'(k % 4));
      tick();
      chk($sformatf("t2_gap%0d", k), 32'(bus.o_dout_valid), 32'd0);
    end
    bus.iv_din_valid = 4'h0;

    // 3: FIR stalls 10 cycles, word held, single ack
    do_reset();
    set_word(1, 16'hBEEF);
    bus.iv_din_valid = 4'b0010;
    bus.i_fir_ready  = 1'b0;
    ack_pulses = 0;
    tick();
    chk_grant("t3", 1, 16'hBEEF);
    if (bus.ov_ack[1]) ack_pulses++;
    bus.iv_din_valid = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("t3_hold%0d", i), {bus.o_dout_valid, bus.ov_dout_ch, 13'd0, bus.ov_dout},
          {1'b1, 2'd1, 13'd0, 16'hBEEF});
      if (bus.ov_ack[1]) ack_pulses++;
    end
    bus.i_fir_ready = 1'b1;
    tick();
    chk("t3_xfer", 32'(bus.o_dout_valid), 32'd0);
    chk("t3_acks", 32'(ack_pulses), 32'd1);

    // 4: watchdog with FIR stuck not-ready
    do_reset();
    set_word(0, 16'h0C0C);
    bus.iv_din_valid = 4'b0001;
    bus.i_fir_ready  = 1'b0;
    tick();
    bus.iv_din_valid = 4'b0000;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("t4_to_low%0d", i), 32'(timeout), 32'd0);
    end
    tick();
    chk("t4_to_rise", 32'(timeout), 32'd1);
    tick();
    tick();
    chk("t4_to_stay", 32'(timeout), 32'd1);
    bus.i_fir_ready = 1'b1;
    tick();
    chk("t4_to_sticky", 32'(timeout), 32'd1);
    do_reset();
    chk("t4_to_clr", 32'(timeout), 32'd0);

    // 5: channel 2 masked, rotation 0,1,3
    bus.iv_ch_en = 4'b1011;
    for (int c = 0; c < 4; c++) set_word(c, 16'h2000 + 16'(c));
    bus.iv_din_valid = 4'hF;
    bus.i_fir_ready  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_grant($sformatf("t5_g%0d", k), seq5[k], 16'h2000 + 16'(seq5[k]));
      tick();
    end
    bus.iv_din_valid = 4'h0;
    bus.iv_ch_en     = 4'hF;

    // 6: freeze during ISSUE, then reset mid-ISSUE
    do_reset();
    set_word(2, 16'h5A5A);
    bus.iv_din_valid = 4'b0100;
    bus.i_fir_ready  = 1'b0;
    tick();
    chk_grant("t6_cap", 2, 16'h5A5A);
    en = 1'b0;
    set_word(0, 16'h0F0F);
    bus.iv_din_valid = 4'b0101;
    bus.i_fir_ready  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_grant($sformatf("t6_frz%0d", i), 2, 16'h5A5A);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_ack",  32'(bus.ov_ack), 32'd0);
    chk("t6_rst_dout", 32'(bus.ov_dout), 32'd0);
    chk("t6_rst_ch",   32'(bus.ov_dout_ch), 32'd0);
    chk("t6_rst_vld",  32'(bus.o_dout_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    en = 1'b1;
    tick();
    chk_grant("t6_next", 0, 16'h0F0F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
